issue_queue_flush_index_returner: RTL and testbench
===================================================

Name: issue_queue_flush_index_returner

Overview:
- On a selective flush, walks the issue queue's flushed-entry mask and streams freed entry indices to the issue queue free list.
- Drives the free list's dedicated return-index port, up to ISSUE_QUEUE_RETURN_INDEX_WIDTH indices per cycle, over exactly ISSUE_QUEUE_RETURN_INDEX_CYCLE non-stalled cycles.
- This is the transmitting end of that free-list return port; the free list is the receiver.

Parameters:
- ENTRY_NUM, 16 (ISSUE_QUEUE_ENTRY_NUM): issue queue entries.
- RETURN_WIDTH, 4 (ISSUE_QUEUE_RETURN_INDEX_WIDTH): indices returned per cycle.
- RETURN_CYCLE, (ENTRY_NUM-1)/RETURN_WIDTH+1: number of groups; integer ceiling division.
- INDEX_BIT_WIDTH, $clog2(ENTRY_NUM): width of one index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flushStart  in  1  one-cycle request to begin returning.
- flushMask  in  ENTRY_NUM  bit i = 1 means entry i is flushed. Sampled only when flushStart is accepted.
- returnStall  in  1  free list cannot accept this cycle.
- busy  out  1  return sequence in progress.
- returnValid  out  RETURN_WIDTH  per-lane valid.
- returnIndex  out  RETURN_WIDTH*INDEX_BIT_WIDTH  per-lane index; lane k occupies bits [k*INDEX_BIT_WIDTH +: INDEX_BIT_WIDTH].
- done  out  1  pulses in the cycle the final group is delivered.
- startDropped  out  1  pulses for a flushStart that arrives while busy.

Behaviour:
- State machine has two states.
  - IDLE: no return in progress.
  - RETURN: registers hold maskReg[ENTRY_NUM] and groupCnt[$clog2(RETURN_CYCLE) bits; minimum width 1].
- Reset (async, any time, including mid-sequence):
  - State goes to IDLE; maskReg and groupCnt go to 0.
  - All outputs read 0 while rst is high and in the first cycle after it. No partial sequence resumes.
- IDLE with flushStart=1 in cycle T:
  - maskReg <= flushMask; groupCnt <= 0; RETURN from T+1.
  - No output activity in cycle T.
- RETURN, each cycle, combinational from registers:
  - Lane k candidate index is e = groupCnt*RETURN_WIDTH + k.
  - returnIndex[k] = e truncated to INDEX_BIT_WIDTH.
  - returnValid[k] = !returnStall && e < ENTRY_NUM && maskReg[e]. Indices at or beyond ENTRY_NUM are never valid, which covers a ragged last group.
  - busy = 1.
- RETURN with returnStall=1:
  - groupCnt and maskReg hold; returnValid all 0; done = 0.
- RETURN with returnStall=0:
  - If groupCnt == RETURN_CYCLE-1: done = 1 and next state is IDLE.
  - Otherwise groupCnt increments.
- Groups with no mask bits still consume a cycle. Total latency is therefore exactly RETURN_CYCLE non-stalled cycles regardless of how many mask bits are set.
- An empty mask (all 0) still runs the full sequence: zero valid lanes and a done pulse.
- flushStart while in RETURN:
  - Ignored, and startDropped = 1 that cycle.
  - The in-flight sequence is unaffected.
  - Upstream guarantees this does not occur; the bench flags it.
- flushStart in the same cycle done is asserted:
  - Also dropped, because state is still RETURN.
  - The earliest accepted restart is the cycle after done.
- Every index set in flushMask is emitted exactly once, in ascending order by group and lane. No index outside the mask is ever emitted.
- busy is 0 in IDLE. done and startDropped are never high in IDLE except as stated.

Test Plan:
1. Reset, then flushStart with flushMask=16'hFFFF, no stall.
   - Cycles T+1..T+4 show returnValid=4'hF with indices {0,1,2,3}, {4..7}, {8..11}, {12..15}.
   - done only at T+4; busy=0 at T+5.
2. flushMask=16'h8001, no stall.
   - T+1: lane0 valid, index 0.
   - T+2, T+3: returnValid=0.
   - T+4: lane3 valid, index 15, done=1.
3. flushMask=16'h00F0 with returnStall high at T+2 and T+3.
   - Group 1 (indices 4..7) appears valid at T+4.
   - done at T+6; each index emitted once.
4. ENTRY_NUM=12, RETURN_WIDTH=5, mask all ones.
   - Groups {0..4}, {5..9}, {10,11} in 3 cycles.
   - Lanes 2..4 invalid in the last group; done in cycle 3.
5. flushStart again at T+2 during sequence 1.
   - startDropped=1 at T+2; sequence unchanged; done at T+4.
6. rst asserted at T+2 mid-sequence.
   - Outputs go to 0 immediately (async); IDLE.
   - A new flushStart with mask 16'h0002 yields index 1 in its first group, with no leftover indices from the aborted sequence.

Source files
------------

// File: rtl/issue_queue_flush_index_returner.sv
// ---------------------------------------------------------------------------
// issue_queue_flush_index_returner
//
// On a selective flush this block walks the flushed-entry mask of the issue
// queue one group of RETURN_WIDTH entries per cycle and streams the freed
// entry indices into the free list's return-index port.
//
// A sequence always takes exactly RETURN_CYCLE non-stalled cycles, however
// many mask bits are set. Groups that contain no flushed entry still use up
// their cycle, and an all-zero mask still runs to completion and pulses done.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no return in progress; outputs quiet; flushStart is accepted
// RETURN | presenting group groupCnt of maskReg to the free list
//
// Ports
//   clk           clock
//   rst           asynchronous active-high reset
//   flushStart    one-cycle request to begin returning (accepted in IDLE)
//   flushMask     bit i set = entry i flushed; sampled on acceptance
//   returnStall   free list cannot accept this cycle
//   busy          return sequence in progress
//   returnValid   per-lane valid
//   returnIndex   per-lane index, lane k at [k*INDEX_BIT_WIDTH +: INDEX_BIT_WIDTH]
//   done          pulses in the cycle the final group is delivered
//   startDropped  pulses for a flushStart that arrives while busy
// ---------------------------------------------------------------------------
module issue_queue_flush_index_returner #(
    parameter int ENTRY_NUM       = 16,
    parameter int RETURN_WIDTH    = 4,
    parameter int RETURN_CYCLE    = (ENTRY_NUM - 1) / RETURN_WIDTH + 1,
    parameter int INDEX_BIT_WIDTH = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flushStart,
    input  logic [ENTRY_NUM-1:0]                    flushMask,
    input  logic                                    returnStall,
    output logic                                    busy,
    output logic [RETURN_WIDTH-1:0]                 returnValid,
    output logic [RETURN_WIDTH*INDEX_BIT_WIDTH-1:0] returnIndex,
    output logic                                    done,
    output logic                                    startDropped
);

    localparam int CNT_WIDTH = (RETURN_CYCLE > 1) ? $clog2(RETURN_CYCLE) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_GROUP = CNT_WIDTH'(RETURN_CYCLE - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        RETURN = 1'b1
    } stateType;

    stateType               state;
    stateType               stateNext;
    logic [ENTRY_NUM-1:0]   maskReg;
    logic [ENTRY_NUM-1:0]   maskNext;
    logic [CNT_WIDTH-1:0]   groupCnt;
    logic [CNT_WIDTH-1:0]   groupCntNext;

    // Mask regrouped per return cycle; lanes past ENTRY_NUM in a ragged
    // last group are tied low so they can never be reported valid.
    logic [RETURN_WIDTH-1:0]                 groupMask [RETURN_CYCLE];
    logic [RETURN_WIDTH*INDEX_BIT_WIDTH-1:0] laneIndex;

    for (genvar g = 0; g < RETURN_CYCLE; g++) begin : genGroup
        for (genvar k = 0; k < RETURN_WIDTH; k++) begin : genLane
            if (g * RETURN_WIDTH + k < ENTRY_NUM) begin : genReal
                assign groupMask[g][k] = maskReg[g * RETURN_WIDTH + k];
            end else begin : genPad
                assign groupMask[g][k] = 1'b0;
            end
        end
    end

    // Candidate index per lane; truncation only matters for padded lanes,
    // which are never valid.
    for (genvar k = 0; k < RETURN_WIDTH; k++) begin : genIndex
        assign laneIndex[k*INDEX_BIT_WIDTH +: INDEX_BIT_WIDTH] =
            INDEX_BIT_WIDTH'(32'(groupCnt) * 32'(RETURN_WIDTH) + 32'(k));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            maskReg  <= '0;
            groupCnt <= '0;
        end else begin
            state    <= stateNext;
            maskReg  <= maskNext;
            groupCnt <= groupCntNext;
        end
    end

    always_comb begin
        stateNext    = state;
        maskNext     = maskReg;
        groupCntNext = groupCnt;
        busy         = 1'b0;
        done         = 1'b0;
        startDropped = 1'b0;
        returnValid  = '0;
        returnIndex  = '0;

        unique case (state)
            IDLE: begin
                if (flushStart) begin
                    maskNext     = flushMask;
                    groupCntNext = '0;
                    stateNext    = RETURN;
                end
            end
            RETURN: begin
                busy         = 1'b1;
                // A start during RETURN (including the done cycle) is never
                // queued; the in-flight walk continues untouched.
                startDropped = flushStart;
                returnIndex  = laneIndex;
                if (!returnStall) begin
                    returnValid = groupMask[groupCnt];
                    if (groupCnt == LAST_GROUP) begin
                        done      = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        groupCntNext = groupCnt + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_issue_queue_flush_index_returner.sv
// ---------------------------------------------------------------------------
// tb_issue_queue_flush_index_returner
//
// Bench for issue_queue_flush_index_returner. A 16-entry / 4-lane instance
// covers most scenarios; a 12-entry / 5-lane instance covers the ragged last
// group. Every accepted flush pushes its expected indices (ascending) into a
// queue; a negedge monitor pops one entry per valid lane and compares.
// ---------------------------------------------------------------------------
module tb_issue_queue_flush_index_returner;

    logic        clk = 1'b0;
    logic        rst;

    logic        flushStart;
    logic [15:0] flushMask;
    logic        returnStall;
    logic        busy;
    logic [3:0]  returnValid;
    logic [15:0] returnIndex;
    logic        done;
    logic        startDropped;

    logic        flushStart12;
    logic [11:0] flushMask12;
    logic        returnStall12;
    logic        busy12;
    logic [4:0]  returnValid12;
    logic [19:0] returnIndex12;
    logic        done12;
    logic        startDropped12;

    int checks = 0;
    int errors = 0;
    int expQ[$];
    int expQ12[$];

    always #5 clk = ~clk;

    issue_queue_flush_index_returner dut (
        .clk          (clk),
        .rst          (rst),
        .flushStart   (flushStart),
        .flushMask    (flushMask),
        .returnStall  (returnStall),
        .busy         (busy),
        .returnValid  (returnValid),
        .returnIndex  (returnIndex),
        .done         (done),
        .startDropped (startDropped)
    );

    issue_queue_flush_index_returner #(
        .ENTRY_NUM    (12),
        .RETURN_WIDTH (5)
    ) dut12 (
        .clk          (clk),
        .rst          (rst),
        .flushStart   (flushStart12),
        .flushMask    (flushMask12),
        .returnStall  (returnStall12),
        .busy         (busy12),
        .returnValid  (returnValid12),
        .returnIndex  (returnIndex12),
        .done         (done12),
        .startDropped (startDropped12)
    );

    // Scoreboard monitors: each valid lane must match the next expected index.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (returnValid[k]) begin
                    int e;
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("FAIL sb16_extra: lane %0d emitted index %0d, required no emission", k, returnIndex[k*4 +: 4]);
                    end else begin
                        e = expQ.pop_front();
                        if (returnIndex[k*4 +: 4] !== 4'(e)) begin
                            errors++;
                            $display("FAIL sb16_index: lane %0d got %0d, required %0d", k, returnIndex[k*4 +: 4], e);
                        end
                    end
                end
            end
            for (int k = 0; k < 5; k++) begin
                if (returnValid12[k]) begin
                    int e;
                    checks++;
                    if (expQ12.size() == 0) begin
                        errors++;
                        $display("FAIL sb12_extra: lane %0d emitted index %0d, required no emission", k, returnIndex12[k*4 +: 4]);
                    end else begin
                        e = expQ12.pop_front();
                        if (returnIndex12[k*4 +: 4] !== 4'(e)) begin
                            errors++;
                            $display("FAIL sb12_index: lane %0d got %0d, required %0d", k, returnIndex12[k*4 +: 4], e);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] mask);
        flushStart = 1'b1;
        flushMask  = mask;
        for (int i = 0; i < 16; i++) if (mask[i]) expQ.push_back(i);
    endtask

    function automatic logic [15:0] groupIdx16(input int g);
        logic [15:0] v;
        for (int k = 0; k < 4; k++) v[k*4 +: 4] = 4'(g * 4 + k);
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        flushStart = 1'b1;
        flushMask = 16'hFFFF;
        #2;
        checks++;
        if ({busy, done, startDropped, returnValid, returnIndex} !== 23'd0) begin
            errors++;
            $display("FAIL reset_during: outputs %h, required 0", {busy, done, startDropped, returnValid, returnIndex});
        end
        tick();
        tick();
        rst = 1'b0;
        flushStart = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, startDropped, returnValid, returnIndex, busy12, returnValid12} !== 29'd0) begin
            errors++;
            $display("FAIL reset_after: outputs %h, required 0", {busy, done, startDropped, returnValid, returnIndex});
        end
        tick();
    endtask

    // Walks a 4-cycle sequence after launch; expVal[c] is returnValid at T+1+c.
    task automatic runSeq(input string name, input logic [15:0] mask, input logic [3:0] expVal [4]);
        launch(mask);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || returnValid !== 4'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_cycleT: busy %b valid %h done %b, required 0 0 0", name, busy, returnValid, done);
        end
        tick();
        flushStart = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (returnValid !== expVal[c] || returnIndex !== groupIdx16(c)) begin
                errors++;
                $display("FAIL %s_group%0d: valid %h idx %h, required %h %h", name, c, returnValid, returnIndex, expVal[c], groupIdx16(c));
            end
            checks++;
            if (busy !== 1'b1 || done !== (c == 3)) begin
                errors++;
                $display("FAIL %s_flags%0d: busy %b done %b, required 1 %b", name, c, busy, done, c == 3);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || expQ.size() != 0) begin
            errors++;
            $display("FAIL %s_end: busy %b done %b pending %0d, required 0 0 0", name, busy, done, expQ.size());
        end
        tick();
    endtask

    task automatic test_full_mask();
        logic [3:0] v [4] = '{4'hF, 4'hF, 4'hF, 4'hF};
        runSeq("full", 16'hFFFF, v);
    endtask

    task automatic test_sparse();
        logic [3:0] v [4] = '{4'h1, 4'h0, 4'h0, 4'h8};
        runSeq("sparse", 16'h8001, v);
    endtask

    task automatic test_empty();
        logic [3:0] v [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
        runSeq("empty", 16'h0000, v);
    endtask

    task automatic test_stall();
        logic [3:0] v [6] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
        launch(16'h00F0);
        tick();
        flushStart = 1'b0;
        for (int c = 0; c < 6; c++) begin
            returnStall = (c == 1 || c == 2);
            @(negedge clk);
            checks++;
            if (returnValid !== v[c] || done !== (c == 5) || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_c%0d: valid %h done %b busy %b, required %h %b 1", c + 1, returnValid, done, busy, v[c], c == 5);
            end
            if (c == 3) begin
                checks++;
                if (returnIndex !== groupIdx16(1)) begin
                    errors++;
                    $display("FAIL stall_index: idx %h, required %h", returnIndex, groupIdx16(1));
                end
            end
            tick();
        end
        returnStall = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || expQ.size() != 0) begin
            errors++;
            $display("FAIL stall_end: busy %b pending %0d, required 0 0", busy, expQ.size());
        end
        tick();
    endtask

    task automatic test_ragged();
        logic [4:0]  v [3] = '{5'h1F, 5'h1F, 5'h03};
        logic [19:0] ei;
        flushStart12 = 1'b1;
        flushMask12 = 12'hFFF;
        for (int i = 0; i < 12; i++) expQ12.push_back(i);
        tick();
        flushStart12 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 5; k++) ei[k*4 +: 4] = 4'(c * 5 + k);
            @(negedge clk);
            checks++;
            if (returnValid12 !== v[c] || returnIndex12 !== ei || done12 !== (c == 2)) begin
                errors++;
                $display("FAIL ragged_c%0d: valid %h idx %h done %b, required %h %h %b", c + 1, returnValid12, returnIndex12, done12, v[c], ei, c == 2);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (busy12 !== 1'b0 || expQ12.size() != 0) begin
            errors++;
            $display("FAIL ragged_end: busy %b pending %0d, required 0 0", busy12, expQ12.size());
        end
        tick();
    endtask

    task automatic test_back_to_back();
        launch(16'hFFFF);
        tick();
        flushStart = 1'b0;
        tick();
        flushStart = 1'b1;
        flushMask = 16'h0001;
        @(negedge clk);
        checks++;
        if (startDropped !== 1'b1 || returnValid !== 4'hF) begin
            errors++;
            $display("FAIL drop_busy: startDropped %b valid %h, required 1 f", startDropped, returnValid);
        end
        tick();
        flushStart = 1'b0;
        @(negedge clk);
        checks++;
        if (startDropped !== 1'b0) begin
            errors++;
            $display("FAIL drop_clear: startDropped %b, required 0", startDropped);
        end
        tick();
        flushStart = 1'b1;
        flushMask = 16'h0002;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || startDropped !== 1'b1) begin
            errors++;
            $display("FAIL drop_done: done %b startDropped %b, required 1 1", done, startDropped);
        end
        tick();
        launch(16'h0004);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || startDropped !== 1'b0) begin
            errors++;
            $display("FAIL restart_accept: busy %b startDropped %b, required 0 0", busy, startDropped);
        end
        tick();
        flushStart = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || returnValid !== ((c == 0) ? 4'h4 : 4'h0) || done !== (c == 3)) begin
                errors++;
                $display("FAIL restart_c%0d: busy %b valid %h done %b, required 1 %h %b", c + 1, busy, returnValid, done, (c == 0) ? 4'h4 : 4'h0, c == 3);
            end
            tick();
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL b2b_pending: %0d left, required 0", expQ.size());
        end
    endtask

    task automatic test_reset_abort();
        launch(16'hFFFF);
        tick();
        flushStart = 1'b0;
        tick();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, startDropped, returnValid, returnIndex} !== 23'd0) begin
            errors++;
            $display("FAIL abort_async: outputs %h, required 0", {busy, done, startDropped, returnValid, returnIndex});
        end
        expQ.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, startDropped, returnValid, returnIndex} !== 23'd0) begin
            errors++;
            $display("FAIL abort_after: outputs %h, required 0", {busy, done, startDropped, returnValid, returnIndex});
        end
        tick();
        launch(16'h0002);
        tick();
        flushStart = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (returnValid !== ((c == 0) ? 4'h2 : 4'h0) || done !== (c == 3)) begin
                errors++;
                $display("FAIL abort_c%0d: valid %h done %b, required %h %b", c + 1, returnValid, done, (c == 0) ? 4'h2 : 4'h0, c == 3);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || expQ.size() != 0) begin
            errors++;
            $display("FAIL abort_end: busy %b pending %0d, required 0 0", busy, expQ.size());
        end
    endtask

    initial begin
        flushStart = 1'b0;
        flushMask = '0;
        returnStall = 1'b0;
        flushStart12 = 1'b0;
        flushMask12 = '0;
        returnStall12 = 1'b0;
        test_reset();
        test_full_mask();
        test_sparse();
        test_stall();
        test_empty();
        test_ragged();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
